// File: rtl/sap_master_responder.sv
// SAP master-interface slave: serves one read or write transaction at a time
// from an internal C_MEM_DEPTH x 128-bit register array, with tag/error reporting.
module sap_master_responder #(
   parameter int C_MEM_DEPTH = 256
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          master_request_i,
   output logic          master_request_ack_o,
   output logic          master_request_complete_o,
   output logic [6:0]    master_request_error_o,
   output logic [3:0]    master_request_tag_o,
   input  logic [3:0]    master_request_type_i,
   input  logic [3:0]    master_request_option_i,
   input  logic [9:0]    master_request_flow_i,
   input  logic [63:0]   master_request_local_address_i,
   input  logic [35:0]   master_request_length_i,
   input  logic          master_descriptor_src_rdy_i,
   output logic          master_descriptor_dst_rdy_o,
   output logic [3:0]    master_descriptor_tag_o,
   input  logic [127:0]  master_descriptor_i,
   output logic          master_datain_src_rdy_o,
   input  logic          master_datain_dst_rdy_i,
   output logic [3:0]    master_datain_tag_o,
   output logic [3:0]    master_datain_option_o,
   output logic [127:0]  master_datain_o,
   input  logic          master_dataout_src_rdy_i,
   output logic          master_dataout_dst_rdy_o,
   output logic [3:0]    master_dataout_tag_o,
   output logic [3:0]    master_dataout_option_o,
   input  logic [127:0]  master_dataout_i
);

   localparam int C_ADDR_WIDTH = $clog2(C_MEM_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ACK      = 3'd1,
      S_READ     = 3'd2,
      S_WRITE    = 3'd3,
      S_COMPLETE = 3'd4
   } state_t;

   logic [127:0]            mem_q [C_MEM_DEPTH];
   state_t                  state_q;
   logic [3:0]              tag_q;
   logic [6:0]              err_q;
   logic                    is_write_q;
   logic [C_ADDR_WIDTH-1:0] ptr_q;
   logic [31:0]             cnt_q;

   logic                    ack_q;
   logic                    complete_q;
   logic [3:0]              req_tag_q;
   logic [6:0]              req_err_q;
   logic                    din_src_rdy_q;
   logic [3:0]              din_tag_q;
   logic [3:0]              din_opt_q;
   logic                    dout_dst_rdy_q;
   logic [3:0]              dout_tag_q;
   logic [3:0]              dout_opt_q;

   logic [6:0]              err_d;
   logic [36:0]             addr_end_s;
   logic                    addr_hi_s;
   logic                    unused_inputs_s;

   assign unused_inputs_s = ^{master_request_option_i, master_request_flow_i,
                              master_descriptor_i, master_descriptor_src_rdy_i};

   // Classify the incoming request; earlier checks take priority over later ones.
   always_comb begin
      err_d      = 7'h00;
      addr_end_s = master_request_local_address_i[40:4] +
                   {5'd0, master_request_length_i[35:4]};
      addr_hi_s  = (master_request_local_address_i >> (C_ADDR_WIDTH + 4)) != 64'd0;
      if (master_request_type_i > 4'd1) begin
         err_d = 7'h01;
      end else if ((master_request_length_i == 36'd0) ||
                   (master_request_length_i[3:0] != 4'd0) ||
                   (master_request_local_address_i[3:0] != 4'd0)) begin
         err_d = 7'h02;
      end else if ((addr_end_s > 37'(C_MEM_DEPTH)) || addr_hi_s) begin
         err_d = 7'h04;
      end else begin
         err_d = 7'h00;
      end
   end

   // Transaction FSM; every interface output is a register updated alongside the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         tag_q          <= 4'd1;
         err_q          <= 7'h00;
         is_write_q     <= 1'b0;
         ptr_q          <= '0;
         cnt_q          <= 32'd0;
         ack_q          <= 1'b0;
         complete_q     <= 1'b0;
         req_tag_q      <= 4'd0;
         req_err_q      <= 7'h00;
         din_src_rdy_q  <= 1'b0;
         din_tag_q      <= 4'd0;
         din_opt_q      <= 4'd0;
         dout_dst_rdy_q <= 1'b0;
         dout_tag_q     <= 4'd0;
         dout_opt_q     <= 4'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (master_request_i) begin
                  is_write_q <= master_request_type_i[0];
                  err_q      <= err_d;
                  ptr_q      <= master_request_local_address_i[C_ADDR_WIDTH+3:4];
                  cnt_q      <= master_request_length_i[35:4];
                  ack_q      <= 1'b1;
                  req_tag_q  <= tag_q;
                  state_q    <= S_ACK;
               end else begin
                  state_q    <= S_IDLE;
               end
            end
            S_ACK: begin
               ack_q     <= 1'b0;
               req_tag_q <= 4'd0;
               if (err_q != 7'h00) begin
                  complete_q <= 1'b1;
                  req_tag_q  <= tag_q;
                  req_err_q  <= err_q;
                  state_q    <= S_COMPLETE;
               end else if (!is_write_q) begin
                  din_src_rdy_q <= 1'b1;
                  din_tag_q     <= tag_q;
                  din_opt_q     <= (cnt_q == 32'd1) ? 4'h1 : 4'h0;
                  state_q       <= S_READ;
               end else begin
                  dout_dst_rdy_q <= 1'b1;
                  dout_tag_q     <= tag_q;
                  dout_opt_q     <= (cnt_q == 32'd1) ? 4'h1 : 4'h0;
                  state_q        <= S_WRITE;
               end
            end
            S_READ: begin
               if (master_datain_dst_rdy_i) begin
                  ptr_q <= ptr_q + C_ADDR_WIDTH'(1);
                  cnt_q <= cnt_q - 32'd1;
                  if (cnt_q == 32'd1) begin
                     din_src_rdy_q <= 1'b0;
                     din_tag_q     <= 4'd0;
                     din_opt_q     <= 4'd0;
                     complete_q    <= 1'b1;
                     req_tag_q     <= tag_q;
                     req_err_q     <= err_q;
                     state_q       <= S_COMPLETE;
                  end else begin
                     din_opt_q     <= (cnt_q == 32'd2) ? 4'h1 : 4'h0;
                  end
               end else begin
                  state_q <= S_READ;
               end
            end
            S_WRITE: begin
               if (master_dataout_src_rdy_i) begin
                  ptr_q <= ptr_q + C_ADDR_WIDTH'(1);
                  cnt_q <= cnt_q - 32'd1;
                  if (cnt_q == 32'd1) begin
                     dout_dst_rdy_q <= 1'b0;
                     dout_tag_q     <= 4'd0;
                     dout_opt_q     <= 4'd0;
                     complete_q     <= 1'b1;
                     req_tag_q      <= tag_q;
                     req_err_q      <= err_q;
                     state_q        <= S_COMPLETE;
                  end else begin
                     dout_opt_q     <= (cnt_q == 32'd2) ? 4'h1 : 4'h0;
                  end
               end else begin
                  state_q <= S_WRITE;
               end
            end
            S_COMPLETE: begin
               complete_q <= 1'b0;
               req_tag_q  <= 4'd0;
               req_err_q  <= 7'h00;
               // Tag 0 is reserved, so the sequence wraps 15 -> 1.
               tag_q      <= (tag_q == 4'd15) ? 4'd1 : tag_q + 4'd1;
               state_q    <= S_IDLE;
            end
            default: begin
               ack_q          <= 1'b0;
               complete_q     <= 1'b0;
               req_tag_q      <= 4'd0;
               req_err_q      <= 7'h00;
               din_src_rdy_q  <= 1'b0;
               din_tag_q      <= 4'd0;
               din_opt_q      <= 4'd0;
               dout_dst_rdy_q <= 1'b0;
               dout_tag_q     <= 4'd0;
               dout_opt_q     <= 4'd0;
               state_q        <= S_IDLE;
            end
         endcase
      end
   end

   // Backing store; deliberately not reset so aborted transfers keep completed beats.
   always_ff @(posedge clk) begin
      if (dout_dst_rdy_q && master_dataout_src_rdy_i) begin
         mem_q[ptr_q] <= master_dataout_i;
      end
   end

   assign master_request_ack_o        = ack_q;
   assign master_request_complete_o   = complete_q;
   assign master_request_tag_o        = req_tag_q;
   assign master_request_error_o      = req_err_q;
   assign master_descriptor_dst_rdy_o = 1'b0;
   assign master_descriptor_tag_o     = 4'd0;
   assign master_datain_src_rdy_o     = din_src_rdy_q;
   assign master_datain_tag_o         = din_tag_q;
   assign master_datain_option_o      = din_opt_q;
   assign master_datain_o             = din_src_rdy_q ? mem_q[ptr_q] : 128'd0;
   assign master_dataout_dst_rdy_o    = dout_dst_rdy_q;
   assign master_dataout_tag_o        = dout_tag_q;
   assign master_dataout_option_o     = dout_opt_q;

endmodule

// File: tb/tb_sap_master_responder.sv
// Scoreboard bench for sap_master_responder: drivers push expected acks, beats and
// completions; a negedge monitor pops and compares them as the DUT produces them.
module tb_sap_master_responder;

   localparam int DEPTH = 256;

   logic          clk = 1'b0;
   logic          rst;
   logic          request, ack, complete;
   logic [6:0]    req_err;
   logic [3:0]    req_tag, req_type, req_option;
   logic [9:0]    req_flow;
   logic [63:0]   req_addr;
   logic [35:0]   req_len;
   logic          desc_src_rdy, desc_dst_rdy;
   logic [3:0]    desc_tag;
   logic [127:0]  desc;
   logic          din_src_rdy, din_dst_rdy;
   logic [3:0]    din_tag, din_opt;
   logic [127:0]  din;
   logic          dout_src_rdy, dout_dst_rdy;
   logic [3:0]    dout_tag, dout_opt;
   logic [127:0]  dout;

   sap_master_responder #(.C_MEM_DEPTH(DEPTH)) dut (
      .clk                            (clk),
      .rst                            (rst),
      .master_request_i               (request),
      .master_request_ack_o           (ack),
      .master_request_complete_o      (complete),
      .master_request_error_o         (req_err),
      .master_request_tag_o           (req_tag),
      .master_request_type_i          (req_type),
      .master_request_option_i        (req_option),
      .master_request_flow_i          (req_flow),
      .master_request_local_address_i (req_addr),
      .master_request_length_i        (req_len),
      .master_descriptor_src_rdy_i    (desc_src_rdy),
      .master_descriptor_dst_rdy_o    (desc_dst_rdy),
      .master_descriptor_tag_o        (desc_tag),
      .master_descriptor_i            (desc),
      .master_datain_src_rdy_o        (din_src_rdy),
      .master_datain_dst_rdy_i        (din_dst_rdy),
      .master_datain_tag_o            (din_tag),
      .master_datain_option_o         (din_opt),
      .master_datain_o                (din),
      .master_dataout_src_rdy_i       (dout_src_rdy),
      .master_dataout_dst_rdy_o       (dout_dst_rdy),
      .master_dataout_tag_o           (dout_tag),
      .master_dataout_option_o        (dout_opt),
      .master_dataout_i               (dout)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_chk  = 0;

   logic [3:0]   ack_q [$];
   logic [10:0]  cpl_q [$];
   logic [135:0] rd_q  [$];
   logic [7:0]   wr_q  [$];
   logic [127:0] mdl_mem [DEPTH];
   logic [127:0] wdat [4];
   logic [3:0]   mdl_tag;

   task automatic check(input string name, input logic [135:0] got, input logic [135:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   function automatic logic [6:0] ref_err(input logic [3:0] t, input logic [63:0] a,
                                          input logic [35:0] l);
      if (t != 4'd0 && t != 4'd1) return 7'h01;
      if (l == 36'd0 || (l % 16) != 0 || (a % 16) != 0) return 7'h02;
      if (a >= 64'(DEPTH) * 64'd16) return 7'h04;
      if ((a / 16) + 64'(l / 16) > 64'(DEPTH)) return 7'h04;
      return 7'h00;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Negedge monitor: every visible output event is matched against the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         if (ack) begin
            check("ack_expected", ack_q.size() != 0, 1'b1);
            if (ack_q.size() != 0) check("ack_tag", {req_err, req_tag}, {7'h00, ack_q.pop_front()});
         end
         if (complete) begin
            check("cpl_expected", cpl_q.size() != 0, 1'b1);
            if (cpl_q.size() != 0) check("cpl_tag_err", {req_tag, req_err}, cpl_q.pop_front());
         end
         if (!ack && !complete) check("req_idle_zero", {req_tag, req_err}, 0);
         if (din_src_rdy) begin
            check("rd_expected", rd_q.size() != 0, 1'b1);
            if (rd_q.size() != 0) begin
               check("rd_beat", {din_tag, din_opt, din}, rd_q[0]);
               if (din_dst_rdy) void'(rd_q.pop_front());
            end
         end else begin
            check("rd_idle_zero", {din_tag, din_opt, din}, 0);
         end
         if (dout_dst_rdy) begin
            check("wr_expected", wr_q.size() != 0, 1'b1);
            if (wr_q.size() != 0) begin
               check("wr_beat", {dout_tag, dout_opt}, wr_q[0]);
               if (dout_src_rdy) void'(wr_q.pop_front());
            end
         end else begin
            check("wr_idle_zero", {dout_tag, dout_opt}, 0);
         end
         check("desc_zero", {desc_dst_rdy, desc_tag}, 0);
      end
   end

   task automatic check_outputs_zero(input string name);
      check({name, "_ctrl"}, {ack, complete, req_err, req_tag, din_src_rdy, din_tag, din_opt,
                              dout_dst_rdy, dout_tag, dout_opt, desc_dst_rdy, desc_tag}, 0);
      check({name, "_data"}, din, 0);
   endtask

   task automatic flush_model();
      ack_q.delete(); cpl_q.delete(); rd_q.delete(); wr_q.delete();
      mdl_tag = 4'd1;
   endtask

   task automatic reset_dut();
      check("queues_drained", ack_q.size() + cpl_q.size() + rd_q.size() + wr_q.size(), 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      flush_model();
   endtask

   // One request; abort_beat >= 0 asserts rst while that beat is offered.
   task automatic xact(input logic [3:0] typ, input logic [63:0] addr, input logic [35:0] len,
                       input bit stall, input bit hold_req, input int abort_beat);
      logic [6:0] e;
      int nb, p, i, cyc;
      bit hs, seen;
      e  = ref_err(typ, addr, len);
      nb = (e == 7'h00) ? int'(len / 16) : 0;
      p  = int'((addr / 16) % DEPTH);
      ack_q.push_back(mdl_tag);
      cpl_q.push_back({mdl_tag, e});
      for (int k = 0; k < nb; k++) begin
         if (typ == 4'd0) rd_q.push_back({mdl_tag, (k == nb - 1) ? 4'h1 : 4'h0, mdl_mem[(p + k) % DEPTH]});
         else wr_q.push_back({mdl_tag, (k == nb - 1) ? 4'h1 : 4'h0});
      end
      mdl_tag = (mdl_tag == 4'd15) ? 4'd1 : mdl_tag + 4'd1;
      request = 1'b1; req_type = typ; req_addr = addr; req_len = len;
      @(posedge clk); #1;
      if (!hold_req) request = 1'b0;
      i = 0; cyc = 0;
      while (i < nb && cyc < 200) begin
         if (typ == 4'd1) begin
            dout = wdat[i];
            dout_src_rdy = stall ? (cyc % 2 == 0) : 1'b1;
         end else begin
            din_dst_rdy = stall ? (cyc % 2 == 0) : 1'b1;
         end
         if (abort_beat == i) begin
            #2 rst = 1'b1;
            #1 check_outputs_zero("abort_zero");
            flush_model();
            request = 1'b0; dout_src_rdy = 1'b0; din_dst_rdy = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            return;
         end
         @(negedge clk);
         hs = (typ == 4'd1) ? (dout_src_rdy && dout_dst_rdy) : (din_dst_rdy && din_src_rdy);
         @(posedge clk); #1;
         if (hs) begin
            if (typ == 4'd1) mdl_mem[(p + i) % DEPTH] = wdat[i];
            i++;
         end
         cyc++;
      end
      request = 1'b0; dout_src_rdy = 1'b0; din_dst_rdy = 1'b0;
      check("beats_done", i, nb);
      if (!stall && nb > 0) check("beat_latency", cyc, nb + 1);
      cyc = 0; seen = 1'b0;
      while (!seen && cyc < 20) begin
         @(negedge clk);
         seen = complete;
         @(posedge clk); #1;
         cyc++;
      end
      check("cpl_seen", seen, 1'b1);
      check("cpl_latency", cyc, (nb == 0) ? 2 : 1);
   endtask

   initial begin
      rst = 1'b1; request = 1'b0; req_type = 4'd0; req_option = 4'hF; req_flow = 10'h3FF;
      req_addr = 64'd0; req_len = 36'd0; desc_src_rdy = 1'b1; desc = '1;
      din_dst_rdy = 1'b0; dout_src_rdy = 1'b0; dout = 128'd0;
      mdl_tag = 4'd1;
      #3 check_outputs_zero("reset_async");
      repeat (2) @(posedge clk);
      #1 check_outputs_zero("reset_state");
      rst = 1'b0;

      // 64-byte write then read back at 0x20 with dst_rdy toggling and request held high
      for (int k = 0; k < 4; k++) wdat[k] = rnd128();
      xact(4'd1, 64'h20, 36'd64, 1'b0, 1'b0, -1);
      xact(4'd0, 64'h20, 36'd64, 1'b1, 1'b1, -1);
      for (int k = 0; k < 3; k++) wdat[k] = rnd128();
      xact(4'd1, 64'h60, 36'd48, 1'b1, 1'b1, -1);
      xact(4'd0, 64'h60, 36'd48, 1'b0, 1'b0, -1);

      // error classes and memory-end boundaries
      xact(4'd3, 64'h0, 36'd16, 1'b0, 1'b0, -1);
      xact(4'd0, 64'h0, 36'd24, 1'b0, 1'b0, -1);
      xact(4'd0, 64'((DEPTH - 1) * 16), 36'd32, 1'b0, 1'b0, -1);
      xact(4'd1, 64'h1_0000_0000, 36'd16, 1'b0, 1'b0, -1);
      xact(4'd0, 64'h10, 36'd0, 1'b0, 1'b0, -1);
      xact(4'd1, 64'h18, 36'd16, 1'b0, 1'b0, -1);
      xact(4'd2, 64'h18, 36'd0, 1'b0, 1'b0, -1);
      wdat[0] = rnd128();
      xact(4'd1, 64'((DEPTH - 1) * 16), 36'd16, 1'b0, 1'b0, -1);
      xact(4'd0, 64'((DEPTH - 1) * 16), 36'd16, 1'b0, 1'b0, -1);

      // 16 back-to-back single-beat requests from reset: tags 1..15 then 1
      reset_dut();
      for (int k = 0; k < 16; k++) begin
         if (k % 2 == 0) begin
            wdat[0] = rnd128();
            xact(4'd1, 64'((100 + k) * 16), 36'd16, 1'b0, 1'b0, -1);
         end else begin
            xact(4'd0, 64'((99 + k) * 16), 36'd16, 1'b0, 1'b0, -1);
         end
      end

      // reset during the third beat of a 4-beat write
      for (int k = 0; k < 4; k++) wdat[k] = rnd128();
      xact(4'd1, 64'h0, 36'd64, 1'b0, 1'b0, -1);
      for (int k = 0; k < 4; k++) wdat[k] = rnd128();
      xact(4'd1, 64'h0, 36'd64, 1'b0, 1'b0, 2);
      repeat (2) @(posedge clk);
      #1 check_outputs_zero("post_abort");
      xact(4'd0, 64'h0, 36'd64, 1'b0, 1'b0, -1);

      repeat (3) @(posedge clk);
      #1 check("queues_drained", ack_q.size() + cpl_q.size() + rd_q.size() + wr_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sap_master_responder.md
SAP_MASTER_RESPONDER -- requirements
Module: sap_master_responder

Interface
REQ-001 SHALL have parameter C_MEM_DEPTH, default 256, backing memory depth in 128-bit words (power of two, >=2).
REQ-002 SHALL have localparam C_ADDR_WIDTH = clog2(C_MEM_DEPTH), taken from math.vh.
REQ-003 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have request ports: master_request in 1; master_request_ack out 1; master_request_complete out 1; master_request_error out 7; master_request_tag out 4; master_request_type in 4; master_request_option in 4 (ignored); master_request_flow in 10 (ignored); master_request_local_address in 64 (byte address); master_request_length in 36 (bytes).
REQ-006 SHALL have descriptor ports: master_descriptor_src_rdy in 1; master_descriptor_dst_rdy out 1; master_descriptor_tag out 4; master_descriptor in 128 (ignored).
REQ-007 SHALL have read-data ports: master_datain_src_rdy out 1; master_datain_dst_rdy in 1; master_datain_tag out 4; master_datain_option out 4; master_datain out 128.
REQ-008 SHALL have write-data ports: master_dataout_src_rdy in 1; master_dataout_dst_rdy out 1; master_dataout_tag out 4; master_dataout_option out 4; master_dataout in 128.

Function
REQ-009 SHALL be the slave end of the SAP master interface, serving one transaction at a time from an internal C_MEM_DEPTH x 128 register array.
REQ-010 SHALL implement FSM states IDLE, ACK, READ, WRITE, COMPLETE.
REQ-011 IDLE: master_request=1 SHALL latch type, address, length, compute error code, go to ACK next cycle; master_request=0 SHALL stay IDLE.
REQ-012 Error code: type not 0 (read) or 1 (write) -> 7'h01; length==0, length[3:0]!=0 or address[3:0]!=0 -> 7'h02; (address>>4)+(length>>4) > C_MEM_DEPTH (37-bit compare) or any address bit above C_ADDR_WIDTH+3 set -> 7'h04; first match in this order wins; else 7'h00.
REQ-013 ACK: SHALL pulse master_request_ack=1 for exactly one cycle with master_request_tag = current tag; next state COMPLETE if error code != 0, READ if type 0, WRITE if type 1.
REQ-014 Word pointer SHALL start at address[C_ADDR_WIDTH+3:4]; beat counter SHALL start at length>>4 (32 bits).
REQ-015 READ: master_datain_src_rdy=1, master_datain = mem[pointer] (combinational), master_datain_tag = current tag, master_datain_option = 4'h1 on last beat else 4'h0; a beat transfers when src_rdy & dst_rdy; each transfer increments pointer and decrements counter; after last beat go to COMPLETE.
REQ-016 WRITE: master_dataout_dst_rdy=1, master_dataout_tag = current tag, master_dataout_option = 4'h1 on last beat else 4'h0; on src_rdy & dst_rdy write master_dataout into mem[pointer], then same pointer/counter rules; after last beat go to COMPLETE.
REQ-017 Stalls (dst_rdy=0 in READ, src_rdy=0 in WRITE) SHALL hold pointer, counter, data and option stable.
REQ-018 COMPLETE: SHALL pulse master_request_complete=1 for one cycle with master_request_tag = current tag and master_request_error = latched code; tag SHALL then advance 1..15 with wrap 15->1 (0 never issued); next state IDLE.
REQ-019 master_request_tag, master_request_error, datain/dataout tag and option SHALL be 0 outside the states that drive them.
REQ-020 master_request asserted outside IDLE SHALL be ignored (no ack) until IDLE is re-entered.
REQ-021 master_descriptor_dst_rdy and master_descriptor_tag SHALL be constant 0.
REQ-022 Minimum latency: request sampled in IDLE -> ack next cycle -> first beat offered the cycle after -> complete the cycle after the last beat.

Reset
REQ-023 On rst=1, regardless of clk: state=IDLE, tag=1, error latch=0, pointer=0, counter=0, all outputs 0; memory contents SHALL NOT be reset.
REQ-024 rst asserted mid-transaction SHALL abort it with no complete pulse; partial writes already performed SHALL remain.

Verification
REQ-025 Write 64 bytes at addr 0x20, dataout beats A,B,C,D with no stalls -> ack tag 1; dst_rdy 4 cycles; option 1 on beat D only; complete tag 1, error 0; mem[2..5]=A..D.
REQ-026 Read 64 bytes at 0x20 with datain_dst_rdy toggling 1,0,1,0... -> datain A..D in order, each held through stalls; complete tag 2, error 0.
REQ-027 Request type 4'h3 -> ack tag then complete with error 7'h01, no datain/dataout activity; length 24 -> 7'h02; addr (C_MEM_DEPTH-1)*16 with length 32 -> 7'h04.
REQ-028 16 back-to-back successful 16-byte requests -> tags 1,2,...,15,1 in order; tag 0 never seen.
REQ-029 Assert rst during third beat of a 4-beat write -> outputs 0 immediately, no complete; next request acked with tag 1; mem words 0,1 of that write updated, words 2,3 unchanged.
